c4_game_controller: RTL and testbench

Turn sequencer for the 4x4 Connect-4 board. It accepts column-drop requests from the player input logic and applies gravity to place a piece. It owns the board registers (game_board occupancy, player_cells owner) and hands them to the winner-detection block. It waits for that block's registered game_status, then either passes the turn or latches the final result. A per-turn timeout forfeits the turn of an idle player.

---
 rtl/connect4_pkg.sv | 29 ++
 rtl/c4_game_controller_if.sv | 28 ++
 rtl/c4_column_drop.sv | 32 +++
 rtl/c4_game_controller.sv | 165 ++++++++++++++++
 tb/tb_c4_game_controller.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/connect4_pkg.sv
// Shared constants and types for the 4x4 Connect-4 game logic.
package connect4_pkg;

    // Winner-detector status codes
    localparam logic [1:0] STILL_PLAYING = 2'b00;
    localparam logic [1:0] P1_WINS       = 2'b01;
    localparam logic [1:0] P2_WINS       = 2'b10;
    localparam logic [1:0] TIE           = 2'b11;

    // Player identities as stored in player_cells / current_player
    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    // Board geometry: bit index = row*BOARD_COLS + col, row 0 at the bottom
    localparam int BOARD_W    = 16;
    localparam int BOARD_COLS = 4;
    localparam int BOARD_ROWS = 4;

    // Turn sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_MOVE = 3'd1,
        ST_PLACE     = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_EVAL      = 3'd4,
        ST_OVER      = 3'd5
    } c4_state_t;

endpackage

// File: rtl/c4_game_controller_if.sv
// Move handshake between the player input logic and the turn sequencer.
interface c4_game_controller_if;

    logic       move_valid;
    logic [1:0] move_col;
    logic       move_ready;
    logic       move_reject;
    logic       timeout_pulse;

    // Player input logic side
    modport master (
        output move_valid,
        output move_col,
        input  move_ready,
        input  move_reject,
        input  timeout_pulse
    );

    // Turn sequencer side
    modport slave (
        input  move_valid,
        input  move_col,
        output move_ready,
        output move_reject,
        output timeout_pulse
    );

endinterface

// File: rtl/c4_column_drop.sv
// Gravity model: finds the lowest empty cell of a column and flags a full column.
module c4_column_drop
    import connect4_pkg::*;
(
    input  logic [BOARD_W-1:0] board,
    input  logic [1:0]         col,
    output logic [3:0]         idx,
    output logic               full
);

    logic [BOARD_ROWS-1:0] col_bits;

    // Gather the occupancy of the selected column, bottom row in bit 0
    for (genvar gi = 0; gi < BOARD_ROWS; gi++) begin : g_col_bits
        logic [3:0] cell_idx;
        assign cell_idx     = {2'(gi), col};
        assign col_bits[gi] = board[cell_idx];
    end

    assign full = col_bits[BOARD_ROWS-1];

    // Scan top-down so the lowest empty row is the last one to win
    always_comb begin
        idx = {2'(BOARD_ROWS - 1), col};
        for (int r = BOARD_ROWS - 1; r >= 0; r--) begin
            if (!col_bits[r]) begin
                idx = {2'(r), col};
            end
        end
    end

endmodule

// File: rtl/c4_game_controller.sv
// Turn sequencer: owns the board, applies gravity drops, waits for the
// registered winner status and handles per-turn idle timeouts.
module c4_game_controller
    import connect4_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int CNT_W          = 26
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 new_game,
    input  logic [1:0]           game_status,
    c4_game_controller_if.slave  mv,
    output logic [BOARD_W-1:0]   game_board,
    output logic [BOARD_W-1:0]   player_cells,
    output logic                 current_player,
    output logic                 game_over,
    output logic [1:0]           result,
    output logic [4:0]           move_count
);

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]       FULL_COUNT = 5'(BOARD_W);

    c4_state_t          state_q,  state_d;
    logic [BOARD_W-1:0] board_q,  board_d;
    logic [BOARD_W-1:0] cells_q,  cells_d;
    logic               player_q, player_d;
    logic [4:0]         count_q,  count_d;
    logic [1:0]         result_q, result_d;
    logic               over_q,   over_d;
    logic [CNT_W-1:0]   timer_q,  timer_d;
    logic [3:0]         idx_q,    idx_d;
    logic               reject_q, reject_d;
    logic               tmo_q,    tmo_d;

    logic [3:0]         drop_idx;
    logic               col_full;

    c4_column_drop u_column_drop (
        .board (board_q),
        .col   (mv.move_col),
        .idx   (drop_idx),
        .full  (col_full)
    );

    // State and datapath registers; reset aborts any move in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            board_q  <= '0;
            cells_q  <= '0;
            player_q <= P1;
            count_q  <= '0;
            result_q <= STILL_PLAYING;
            over_q   <= 1'b0;
            timer_q  <= '0;
            idx_q    <= '0;
            reject_q <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            cells_q  <= cells_d;
            player_q <= player_d;
            count_q  <= count_d;
            result_q <= result_d;
            over_q   <= over_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            reject_q <= reject_d;
            tmo_q    <= tmo_d;
        end
    end

    // Next-state logic; new_game outranks every move, timeout or evaluation
    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        cells_d  = cells_q;
        player_d = player_q;
        count_d  = count_q;
        result_d = result_q;
        over_d   = over_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        reject_d = 1'b0;
        tmo_d    = 1'b0;

        if (new_game) begin
            state_d  = ST_WAIT_MOVE;
            board_d  = '0;
            cells_d  = '0;
            player_d = P1;
            count_d  = '0;
            result_d = STILL_PLAYING;
            over_d   = 1'b0;
            timer_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_WAIT_MOVE: begin
                    if (mv.move_valid && !col_full) begin
                        // Accepted move beats a coinciding timeout
                        idx_d   = drop_idx;
                        state_d = ST_PLACE;
                    end else begin
                        reject_d = mv.move_valid;
                        if (timer_q == TIMER_LAST) begin
                            tmo_d    = 1'b1;
                            player_d = ~player_q;
                            timer_d  = '0;
                        end else begin
                            timer_d = timer_q + 1'b1;
                        end
                    end
                end
                ST_PLACE: begin
                    board_d[idx_q] = 1'b1;
                    cells_d[idx_q] = player_q;
                    count_d        = count_q + 5'd1;
                    state_d        = ST_SETTLE;
                end
                ST_SETTLE: begin
                    // Detector registers the new board on this edge
                    state_d = ST_EVAL;
                end
                ST_EVAL: begin
                    if (game_status != STILL_PLAYING) begin
                        result_d = game_status;
                        over_d   = 1'b1;
                        state_d  = ST_OVER;
                    end else if (count_q == FULL_COUNT) begin
                        result_d = TIE;
                        over_d   = 1'b1;
                        state_d  = ST_OVER;
                    end else begin
                        player_d = ~player_q;
                        timer_d  = '0;
                        state_d  = ST_WAIT_MOVE;
                    end
                end
                ST_OVER: begin
                    state_d = ST_OVER;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign mv.move_ready    = (state_q == ST_WAIT_MOVE);
    assign mv.move_reject   = reject_q;
    assign mv.timeout_pulse = tmo_q;
    assign game_board       = board_q;
    assign player_cells     = cells_q;
    assign current_player   = player_q;
    assign game_over        = over_q;
    assign result           = result_q;
    assign move_count       = count_q;

endmodule

// File: tb/tb_c4_game_controller.sv
// Directed bench for the Connect-4 turn sequencer with a registered
// winner-detector model closing the loop on game_status.
module tb_c4_game_controller;

    logic        clk;
    logic        rst_n;
    logic        new_game;
    logic [1:0]  game_status;
    logic [15:0] game_board;
    logic [15:0] player_cells;
    logic        current_player;
    logic        game_over;
    logic [1:0]  result;
    logic [4:0]  move_count;

    int total;
    int bad;

    c4_game_controller_if mv_if ();

    c4_game_controller #(
        .TIMEOUT_CYCLES (8),
        .CNT_W          (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .new_game       (new_game),
        .game_status    (game_status),
        .mv             (mv_if.slave),
        .game_board     (game_board),
        .player_cells   (player_cells),
        .current_player (current_player),
        .game_over      (game_over),
        .result         (result),
        .move_count     (move_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Winner detector model: any full line of one owner wins, full board ties
    function automatic logic [1:0] detect(input logic [15:0] b, input logic [15:0] c);
        logic [15:0] masks [10];
        masks = '{16'h000F, 16'h00F0, 16'h0F00, 16'hF000,
                  16'h1111, 16'h2222, 16'h4444, 16'h8888,
                  16'h8421, 16'h1248};
        for (int i = 0; i < 10; i++) begin
            if ((b & masks[i]) == masks[i]) begin
                if ((c & masks[i]) == 16'h0000) return 2'b01;
                if ((c & masks[i]) == masks[i]) return 2'b10;
            end
        end
        if (b == 16'hFFFF) return 2'b11;
        return 2'b00;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) game_status <= 2'b00;
        else        game_status <= detect(game_board, player_cells);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ng;
        logic [1:0]  col;
        logic        rej;
        logic [15:0] board;
        logic [15:0] cells;
        logic        player;
        logic [4:0]  count;
        logic        over;
        logic [1:0]  res;
    } vec_t;

    vec_t vecs [14];

    task automatic do_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(posedge clk);
        #1;
        new_game = 1'b0;
        chk("ng_board", 32'(game_board), 32'h0);
        chk("ng_cells", 32'(player_cells), 32'h0);
        chk("ng_count", 32'(move_count), 32'h0);
        chk("ng_player", 32'(current_player), 32'h0);
        chk("ng_ready", 32'(mv_if.move_ready), 32'h1);
        chk("ng_over", 32'(game_over), 32'h0);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && !mv_if.move_ready; i++) begin
            @(posedge clk);
            #1;
        end
        chk("ready_wait", 32'(mv_if.move_ready), 32'h1);
    endtask

    task automatic apply_vec(input int n);
        vec_t v;
        v = vecs[n];
        if (v.ng) do_new_game();
        wait_ready();
        mv_if.move_valid = 1'b1;
        mv_if.move_col   = v.col;
        @(posedge clk);
        #1;
        mv_if.move_valid = 1'b0;
        if (v.rej) begin
            chk("rej_pulse", 32'(mv_if.move_reject), 32'h1);
            chk("rej_ready", 32'(mv_if.move_ready), 32'h1);
            chk("rej_board", 32'(game_board), 32'(v.board));
            chk("rej_cells", 32'(player_cells), 32'(v.cells));
            chk("rej_player", 32'(current_player), 32'(v.player));
            chk("rej_count", 32'(move_count), 32'(v.count));
            @(posedge clk);
            #1;
            chk("rej_pulse_end", 32'(mv_if.move_reject), 32'h0);
        end else begin
            chk("acc_ready_low", 32'(mv_if.move_ready), 32'h0);
            chk("acc_no_reject", 32'(mv_if.move_reject), 32'h0);
            @(posedge clk);
            #1;
            chk("place_board", 32'(game_board), 32'(v.board));
            chk("place_cells", 32'(player_cells), 32'(v.cells));
            repeat (2) @(posedge clk);
            #1;
            chk("turn_ready", 32'(mv_if.move_ready), 32'(!v.over));
            chk("turn_player", 32'(current_player), 32'(v.player));
            chk("turn_count", 32'(move_count), 32'(v.count));
            chk("turn_over", 32'(game_over), 32'(v.over));
            chk("turn_result", 32'(result), 32'(v.res));
        end
        $display("vec %0d col=%0d board=%h cells=%h player=%0d count=%0d over=%0d result=%0d",
                 n, v.col, game_board, player_cells, current_player, move_count, game_over, result);
    endtask

    // Time limit so a stuck design cannot hang the run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        new_game = 1'b0;
        mv_if.move_valid = 1'b0;
        mv_if.move_col   = 2'd0;

        //           ng    col   rej   board     cells     pl    cnt   over  res
        vecs[0]  = '{1'b1, 2'd0, 1'b0, 16'h0001, 16'h0000, 1'b1, 5'd1, 1'b0, 2'b00};
        vecs[1]  = '{1'b0, 2'd0, 1'b0, 16'h0011, 16'h0010, 1'b0, 5'd2, 1'b0, 2'b00};
        vecs[2]  = '{1'b1, 2'd1, 1'b0, 16'h0002, 16'h0000, 1'b1, 5'd1, 1'b0, 2'b00};
        vecs[3]  = '{1'b0, 2'd1, 1'b0, 16'h0022, 16'h0020, 1'b0, 5'd2, 1'b0, 2'b00};
        vecs[4]  = '{1'b0, 2'd1, 1'b0, 16'h0222, 16'h0020, 1'b1, 5'd3, 1'b0, 2'b00};
        vecs[5]  = '{1'b0, 2'd1, 1'b0, 16'h2222, 16'h2020, 1'b0, 5'd4, 1'b0, 2'b00};
        vecs[6]  = '{1'b0, 2'd1, 1'b1, 16'h2222, 16'h2020, 1'b0, 5'd4, 1'b0, 2'b00};
        vecs[7]  = '{1'b1, 2'd0, 1'b0, 16'h0001, 16'h0000, 1'b1, 5'd1, 1'b0, 2'b00};
        vecs[8]  = '{1'b0, 2'd0, 1'b0, 16'h0011, 16'h0010, 1'b0, 5'd2, 1'b0, 2'b00};
        vecs[9]  = '{1'b0, 2'd1, 1'b0, 16'h0013, 16'h0010, 1'b1, 5'd3, 1'b0, 2'b00};
        vecs[10] = '{1'b0, 2'd1, 1'b0, 16'h0033, 16'h0030, 1'b0, 5'd4, 1'b0, 2'b00};
        vecs[11] = '{1'b0, 2'd2, 1'b0, 16'h0037, 16'h0030, 1'b1, 5'd5, 1'b0, 2'b00};
        vecs[12] = '{1'b0, 2'd2, 1'b0, 16'h0077, 16'h0070, 1'b0, 5'd6, 1'b0, 2'b00};
        vecs[13] = '{1'b0, 2'd3, 1'b0, 16'h007F, 16'h0070, 1'b0, 5'd7, 1'b1, 2'b01};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(mv_if.move_ready), 32'h0);
        chk("rst_board", 32'(game_board), 32'h0);
        chk("rst_count", 32'(move_count), 32'h0);
        rst_n = 1'b1;

        // Table-driven games: two-piece stack, full-column reject, bottom-row win
        for (int n = 0; n < 14; n++) begin
            apply_vec(n);
        end

        // Moves after the game ended are ignored
        mv_if.move_valid = 1'b1;
        mv_if.move_col   = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        mv_if.move_valid = 1'b0;
        chk("over_board", 32'(game_board), 32'h007F);
        chk("over_count", 32'(move_count), 32'd7);
        chk("over_ready", 32'(mv_if.move_ready), 32'h0);
        chk("over_hold", 32'(game_over), 32'h1);
        chk("over_result", 32'(result), 32'h1);
        $display("txn over_ignore board=%h count=%0d", game_board, move_count);

        // Idle timeout after eight WAIT_MOVE cycles
        do_new_game();
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k < 8) chk("tmo_early", 32'(mv_if.timeout_pulse), 32'h0);
        end
        chk("tmo_pulse", 32'(mv_if.timeout_pulse), 32'h1);
        chk("tmo_player", 32'(current_player), 32'h1);
        @(posedge clk);
        #1;
        chk("tmo_pulse_end", 32'(mv_if.timeout_pulse), 32'h0);
        $display("txn timeout player=%0d", current_player);

        // Move on the expiry cycle wins over the timeout
        repeat (6) @(posedge clk);
        #1;
        mv_if.move_valid = 1'b1;
        mv_if.move_col   = 2'd2;
        @(posedge clk);
        #1;
        mv_if.move_valid = 1'b0;
        chk("race_no_pulse", 32'(mv_if.timeout_pulse), 32'h0);
        chk("race_accept", 32'(mv_if.move_ready), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("race_board", 32'(game_board), 32'h0004);
        chk("race_cells", 32'(player_cells), 32'h0004);
        chk("race_player", 32'(current_player), 32'h0);
        chk("race_no_pulse2", 32'(mv_if.timeout_pulse), 32'h0);
        $display("txn race board=%h cells=%h", game_board, player_cells);

        // new_game during SETTLE of a winning move: win must not be latched
        for (int n = 7; n < 13; n++) begin
            apply_vec(n);
        end
        mv_if.move_valid = 1'b1;
        mv_if.move_col   = 2'd3;
        @(posedge clk);
        #1;
        mv_if.move_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("settle_board", 32'(game_board), 32'h007F);
        new_game = 1'b1;
        @(posedge clk);
        #1;
        new_game = 1'b0;
        chk("settle_clr_board", 32'(game_board), 32'h0);
        chk("settle_clr_count", 32'(move_count), 32'h0);
        chk("settle_clr_ready", 32'(mv_if.move_ready), 32'h1);
        repeat (2) @(posedge clk);
        #1;
        chk("settle_no_over", 32'(game_over), 32'h0);
        chk("settle_no_result", 32'(result), 32'h0);
        chk("settle_still_ready", 32'(mv_if.move_ready), 32'h1);
        $display("txn settle_newgame over=%0d result=%0d", game_over, result);

        // Asynchronous reset in the middle of PLACE
        do_new_game();
        mv_if.move_valid = 1'b1;
        mv_if.move_col   = 2'd1;
        @(posedge clk);
        #1;
        mv_if.move_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_board", 32'(game_board), 32'h0);
        chk("arst_count", 32'(move_count), 32'h0);
        chk("arst_ready", 32'(mv_if.move_ready), 32'h0);
        chk("arst_player", 32'(current_player), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mv_if.move_valid = 1'b1;
        mv_if.move_col   = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        mv_if.move_valid = 1'b0;
        chk("arst_idle_board", 32'(game_board), 32'h0);
        chk("arst_idle_ready", 32'(mv_if.move_ready), 32'h0);
        do_new_game();
        $display("txn async_reset board=%h ready=%0d", game_board, mv_if.move_ready);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
